// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and the
// step-counter sizing helper.
package seq_divider_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'b00;
  localparam state_t CALC = 2'b01;
  localparam state_t FIX  = 2'b10;
  localparam state_t DONE = 2'b11;

  function automatic int unsigned cnt_width(input int unsigned width);
    return unsigned'($clog2(width));
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One radix-2 restoring step: shift in the next dividend bit, then subtract
// the divisor magnitude when it fits.
module div_step #(
  parameter int unsigned WIDTH = 19
) (
  input  logic [WIDTH:0]   rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] dsr_mag,
  output logic [WIDTH:0]   next_rem,
  output logic             quo_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Partial remainder is always below the divisor, so its top bit is never set.
  logic unused_rem_msb;
  assign unused_rem_msb = rem[WIDTH];

  assign shifted  = {rem[WIDTH-1:0], dvd_bit};
  assign diff     = shifted - {1'b0, dsr_mag};
  assign quo_bit  = (shifted >= {1'b0, dsr_mag});
  assign next_rem = quo_bit ? diff : shifted;

endmodule

// File: rtl/seq_divider.sv
// Fixed-latency restoring divider with start/busy/done handshake, divide-by-zero
// flag and optional two's-complement (truncating) mode.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH  = 19,
  parameter bit          SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_t state_q, state_d;

  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] dvd_q, dsr_q, quo_q;
  logic [WIDTH:0]   rem_q, step_rem;
  logic             step_bit, dvd_neg_q, quo_neg_q;

  logic             accept, is_zero, dvd_neg, dsr_neg;
  logic [WIDTH-1:0] dvd_mag, dsr_mag, quo_fix, rem_fix;
  logic             busy_d, done_d, load_res, load_zero;

  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;

  assign accept  = (state_q == IDLE) && start;
  assign is_zero = (divisor == '0);
  assign dvd_neg = SIGNED && dividend[WIDTH-1];
  assign dsr_neg = SIGNED && divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dsr_mag = dsr_neg ? -divisor : divisor;

  // Most-negative / -1 wraps naturally: the magnitude 2^(WIDTH-1) negates to itself.
  assign quo_fix = quo_neg_q ? -quo_q : quo_q;
  assign rem_fix = dvd_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem      (rem_q),
    .dvd_bit  (dvd_q[WIDTH-1]),
    .dsr_mag  (dsr_q),
    .next_rem (step_rem),
    .quo_bit  (step_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = is_zero ? DONE : CALC;
      CALC:    if (cnt_q == '0) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // busy/done are registered, so they trail the state by one cycle.
  always_comb begin
    busy_d    = (state_q != IDLE);
    done_d    = (state_q == DONE);
    load_res  = (state_q == FIX);
    load_zero = accept && is_zero;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvd_neg_q <= 1'b0;
      quo_neg_q <= 1'b0;
    end else if (accept) begin
      cnt_q     <= CntW'(WIDTH - 1);
      dvd_q     <= dvd_mag;
      dsr_q     <= dsr_mag;
      quo_q     <= '0;
      rem_q     <= '0;
      dvd_neg_q <= dvd_neg;
      quo_neg_q <= dvd_neg ^ dsr_neg;
    end else if (state_q == CALC) begin
      cnt_q <= cnt_q - CntW'(1);
      dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
      quo_q <= {quo_q[WIDTH-2:0], step_bit};
      rem_q <= step_rem;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      if (load_zero) begin
        quotient_q  <= '1;
        remainder_q <= dividend;
        dbz_q       <= 1'b1;
      end else if (load_res) begin
        quotient_q  <= quo_fix;
        remainder_q <= rem_fix;
        dbz_q       <= 1'b0;
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Parametrised radix-2 restoring sequential divider that computes quotient and remainder.
- Replaces the repeated-subtraction divider used in the game datapath, e.g. score and speed scaling and position-to-tile mapping.
- Fixed latency independent of operand values.
- start/busy/done handshake, divide-by-zero flag and optional signed mode.

Parameters:
- WIDTH, 19, operand, quotient and remainder width in bits (>=2).
- SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands, truncating division.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  WIDTH  numerator; captured when start is accepted.
- divisor  input  WIDTH  denominator; captured when start is accepted.
- busy  output  1  high from the cycle after acceptance until the done cycle inclusive.
- done  output  1  one-cycle pulse; results valid.
- quotient  output  WIDTH  registered; held until the next accepted start.
- remainder  output  WIDTH  registered; held until the next accepted start.
- div_by_zero  output  1  registered; valid with done; held like the results.

Behaviour:
- Clock and reset: reset is reset, asynchronous, active-high; clock is clk.
- Reset values: all outputs 0, state IDLE, step counter 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1:
  - capture operands.
  - SIGNED=1: store magnitudes and the sign of each operand.
  - divisor==0: go to DONE with quotient = all ones, remainder = dividend (raw), div_by_zero=1.
  - otherwise: clear the partial remainder, counter = WIDTH-1, go to CALC.
- CALC, one bit per cycle, MSB first:
  - shift the partial remainder left, bringing in the next dividend bit.
  - if partial remainder >= divisor magnitude, subtract it and set the quotient bit to 1; otherwise set it to 0.
  - after WIDTH cycles go to FIX.
  - The internal partial remainder is WIDTH+1 bits so there is no overflow.
- FIX:
  - SIGNED=1: negate the quotient if the operand signs differ; negate the remainder if the dividend is negative.
  - The quotient rounds toward zero. The remainder takes the dividend's sign.
  - Most-negative / -1 wraps: quotient = most-negative, remainder = 0, no flag.
  - Load the output registers and go to DONE.
- DONE: done=1 for exactly this cycle, then IDLE. busy is 1 in CALC, FIX and DONE.
- Latency, with the start-accepting edge counted as edge 0:
  - normal: done high after edge WIDTH+2, i.e. WIDTH+2 cycles.
  - divide-by-zero: done high after edge 1.
- Back-to-back: start asserted in the cycle after done is accepted. There are no gap cycles beyond IDLE.
- start while busy: ignored; no queuing; operand changes during busy are ignored.
- Equality: dividend == divisor gives quotient 1, remainder 0.
- reset mid-operation: the operation is aborted. Outputs clear immediately (asynchronously). No done pulse is produced.

Decomposition:
- Package seq_divider_pkg holds:
  - the state encoding localparams: IDLE=2'b00, CALC=2'b01, FIX=2'b10, DONE=2'b11.
  - a counter-width function (clog2 of WIDTH).
- Sub-module div_step, combinational, parametrised by WIDTH:
  - inputs: partial remainder, next dividend bit, divisor magnitude.
  - outputs: next partial remainder and quotient bit.
  - The top-level FSM instantiates one div_step.

Test Plan:
- WIDTH=19, SIGNED=0, 100/7 -> quotient=14, remainder=2, div_by_zero=0; done pulses exactly 21 cycles after the accepting edge, one cycle wide; busy is high for 21 cycles.
- 7/7, then 6/7, then 0/5 -> (1,0), (0,6), (0,0); with start held high the next operation is accepted the cycle after each done.
- 5/0 -> quotient=19'h7FFFF, remainder=5, div_by_zero=1; done after 1 cycle; a following 9/3 gives (3,0) and clears div_by_zero.
- SIGNED=1, WIDTH=8:
  - -100/7 -> (-14, -2).
  - 100/-7 -> (-14, 2).
  - -128/-1 -> (-128, 0).
  - all operations have a 10-cycle latency.
- start pulsed with 50/5 in cycle 3 of a busy 100/7 operation -> ignored; results are (14,2) and exactly one done pulse.
- reset asserted mid-CALC -> all outputs 0 immediately and no done; a new 255/16 start then yields (15,15).
